// File: rtl/matmul_pkg.sv
// Shared matmul definitions: default geometry, transmitter FSM encodings, UART byte width.
// RESULT_TX_CHECKSUM_EN adds the checksum state to the transmitter encoding.
package matmul_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_MAX_N  = 8;
    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned UART_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT,
`ifdef RESULT_TX_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_STALL,
        HS_ACK,
        HS_WAIT
    } hs_state_e;

    // Requested matrix dimension limited to what the buffer holds.
    function automatic logic [3:0] clamp_size(input logic [3:0] size, input int unsigned max_n);
        return (32'(size) > max_n) ? 4'(max_n) : size;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte tx_start/tx_busy handshake: waits for a free UART, pulses tx_start,
// waits for busy to rise (2-cycle timeout) and fall, then pulses byte_done.
module tx_byte_handshake
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [UART_W-1:0] tx_byte,
    input  logic              tx_busy,
    output logic              byte_done,
    output logic              tx_start,
    output logic [UART_W-1:0] tx_data
);

    hs_state_e         state;
    logic [UART_W-1:0] pend;
    logic              ack_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HS_IDLE;
            pend      <= '0;
            ack_cnt   <= 1'b0;
            byte_done <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_start  <= 1'b0;
            byte_done <= 1'b0;
            case (state)
                HS_IDLE: begin
                    if (send) begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            tx_data  <= tx_byte;
                            ack_cnt  <= 1'b0;
                            state    <= HS_ACK;
                        end else begin
                            pend  <= tx_byte;
                            state <= HS_STALL;
                        end
                    end
                end
                HS_STALL: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= pend;
                        ack_cnt  <= 1'b0;
                        state    <= HS_ACK;
                    end
                end
                // A UART that never raises busy is treated as having taken the byte.
                HS_ACK: begin
                    if (tx_busy || ack_cnt) begin
                        state <= HS_WAIT;
                    end else begin
                        ack_cnt <= 1'b1;
                    end
                end
                HS_WAIT: begin
                    if (!tx_busy) begin
                        byte_done <= 1'b1;
                        state     <= HS_IDLE;
                    end
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/result_transmitter.sv
// Streams the N x N result matrix row-major, MSB byte first, to the UART TX.
// RESULT_TX_CHECKSUM_EN appends an XOR-of-all-data-bytes checksum byte.
module result_transmitter
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MAX_N  = DEF_MAX_N,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BPE        = DATA_W / UART_W;
    localparam int unsigned BYTE_IDX_W = (BPE > 1) ? $clog2(BPE) : 1;
    localparam int unsigned ELEM_W     = $clog2(MAX_N * MAX_N + 1);
`ifdef RESULT_TX_CHECKSUM_EN
    localparam tx_state_e   AFTER_DATA = ST_CKSUM;
`else
    localparam tx_state_e   AFTER_DATA = ST_DONE;
`endif

    tx_state_e             state;
    logic [DATA_W-1:0]     shift_reg;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [ELEM_W-1:0]     elem_idx;
    logic [ELEM_W-1:0]     elem_total;
    logic [3:0]            n_c;
    logic                  send_c;
    logic [UART_W-1:0]     byte_c;
    logic                  byte_done;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [UART_W-1:0]     cksum;
    logic                  cksum_phase;
`endif

    assign n_c = clamp_size(matrix_size, MAX_N);

    // First byte of an element comes straight from rd_data to save a cycle.
    always_comb begin
        send_c = 1'b0;
        byte_c = shift_reg[DATA_W-1 -: UART_W];
        case (state)
            ST_CAPTURE: begin
                send_c = 1'b1;
                byte_c = rd_data[DATA_W-1 -: UART_W];
            end
            ST_SEND: send_c = 1'b1;
`ifdef RESULT_TX_CHECKSUM_EN
            ST_CKSUM: begin
                send_c = 1'b1;
                byte_c = cksum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            byte_idx   <= '0;
            elem_idx   <= '0;
            elem_total <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            cksum       <= '0;
            cksum_phase <= 1'b0;
`endif
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        elem_idx   <= '0;
                        byte_idx   <= '0;
                        elem_total <= ELEM_W'(n_c) * ELEM_W'(n_c);
`ifdef RESULT_TX_CHECKSUM_EN
                        cksum       <= '0;
                        cksum_phase <= 1'b0;
`endif
                        if (n_c == 4'd0) begin
                            state <= AFTER_DATA;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            state   <= ST_READ;
                        end
                    end
                end
                ST_READ: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    shift_reg <= rd_data;
                    byte_idx  <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
                    cksum <= cksum ^ byte_c;
`endif
                    state <= ST_WAIT;
                end
                ST_SEND: begin
`ifdef RESULT_TX_CHECKSUM_EN
                    cksum <= cksum ^ byte_c;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (byte_done) begin
`ifdef RESULT_TX_CHECKSUM_EN
                        if (cksum_phase) state <= ST_DONE;
                        else
`endif
                        if (byte_idx < BYTE_IDX_W'(BPE - 1)) begin
                            shift_reg <= shift_reg << UART_W;
                            byte_idx  <= byte_idx + BYTE_IDX_W'(1);
                            state     <= ST_SEND;
                        end else if ((elem_idx + ELEM_W'(1)) < elem_total) begin
                            elem_idx <= elem_idx + ELEM_W'(1);
                            rd_en    <= 1'b1;
                            rd_addr  <= ADDR_W'(elem_idx + ELEM_W'(1));
                            state    <= ST_READ;
                        end else begin
                            state <= AFTER_DATA;
                        end
                    end
                end
`ifdef RESULT_TX_CHECKSUM_EN
                ST_CKSUM: begin
                    cksum_phase <= 1'b1;
                    state       <= ST_WAIT;
                end
`endif
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tx_byte_handshake u_hs (
        .clk       (clk),
        .rst       (rst),
        .send      (send_c),
        .tx_byte   (byte_c),
        .tx_busy   (tx_busy),
        .byte_done (byte_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

endmodule

// File: tb/tb_result_transmitter.sv
// Scoreboard bench for result_transmitter with a result-buffer and UART TX model.
module tb_result_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  matrix_size;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    logic [15:0] mem [64];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          byte_cnt = 0;
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    int          first_rd_cyc = -1;
    int          first_tx_cyc = -1;
    int          uart_cnt = 0;
    logic        hold_busy = 1'b0;
    logic        prev_tx   = 1'b0;

    always #5 clk = ~clk;

    result_transmitter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_size (matrix_size),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Synchronous-read result buffer.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Output monitor followed by the UART model (busy for 10 cycles per byte).
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst) begin
            if (tx_start) begin
                check_eq("tx_while_busy", 32'(tx_busy), 0);
                check_eq("tx_back_to_back", 32'(prev_tx), 0);
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_eq("tx_byte", 32'(tx_data), 32'(exp_b));
                end
                byte_cnt++;
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
            end
            if (rd_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", 32'(busy), 0);
            end
        end
        prev_tx = tx_start;
        if (tx_start) uart_cnt = 10;
        else if (uart_cnt != 0) uart_cnt--;
        tx_busy = (uart_cnt != 0) || hold_busy;
    end

    task automatic push_expected(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n * n; i++) begin
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
            x = x ^ mem[i][15:8] ^ mem[i][7:0];
        end
`ifdef RESULT_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic clear_counts();
        byte_cnt = 0;
        rd_cnt = 0;
        first_rd_cyc = -1;
        first_tx_cyc = -1;
    endtask

    task automatic pulse_start(input logic [3:0] size);
        matrix_size = size;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        check_eq("done_once", 32'(done_cnt - d0), 1);
        check_eq("sb_drained", 32'(exp_q.size()), 0);
        check_eq("busy_after_done", 32'(busy), 0);
    endtask

    function automatic int cks_extra();
`ifdef RESULT_TX_CHECKSUM_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        matrix_size = 4'd0;
        tx_busy = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0101 + 16'h0305);
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", 32'(rd_en), 0);
        check_eq("rst_rd_addr", 32'(rd_addr), 0);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // N=3, elements 1..9
        for (int i = 0; i < 9; i++) mem[i] = 16'(i + 1);
        clear_counts();
        push_expected(3);
        pulse_start(4'd3);
        check_eq("busy_after_start", 32'(busy), 1);
        wait_done(2000);
        check_eq("n3_bytes", 32'(byte_cnt), 32'(18 + cks_extra()));
        check_eq("n3_reads", 32'(rd_cnt), 9);
        check_eq("read_to_tx_lat", 32'(first_tx_cyc - first_rd_cyc), 2);

        // N=2 with the UART held busy before the first byte
        mem[0] = 16'hABCD; mem[1] = 16'h1234; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
        clear_counts();
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        push_expected(2);
        pulse_start(4'd2);
        repeat (50) @(negedge clk);
        check_eq("no_tx_while_held", 32'(byte_cnt), 0);
        hold_busy = 1'b0;
        wait_done(2000);
        check_eq("n2_bytes", 32'(byte_cnt), 32'(8 + cks_extra()));

        // N=0
        clear_counts();
        push_expected(0);
        d0 = done_cnt;
        pulse_start(4'd0);
`ifndef RESULT_TX_CHECKSUM_EN
        check_eq("n0_busy_cycle", 32'(busy), 1);
        @(negedge clk);
        check_eq("n0_done_pulse", 32'(done), 1);
        check_eq("n0_busy_drop", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check_eq("n0_done_once", 32'(done_cnt - d0), 1);
`else
        wait_done(500);
`endif
        check_eq("n0_reads", 32'(rd_cnt), 0);
        check_eq("n0_bytes", 32'(byte_cnt), 32'(cks_extra()));

        // Reset after the 5th byte of an N=3 transfer, then a fresh transfer
        for (int i = 0; i < 9; i++) mem[i] = 16'(16'h1111 * (i + 1));
        clear_counts();
        push_expected(3);
        pulse_start(4'd3);
        for (int c = 0; c < 2000 && byte_cnt < 5; c++) @(negedge clk);
        check_eq("reached_5th_byte", 32'(byte_cnt), 5);
        rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check_eq("mid_rst_rd_en", 32'(rd_en), 0);
        check_eq("mid_rst_rd_addr", 32'(rd_addr), 0);
        check_eq("mid_rst_tx_start", 32'(tx_start), 0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("no_done_after_abort", 32'(done_cnt - d0), 0);
        check_eq("no_tx_after_abort", 32'(byte_cnt), 5);
        clear_counts();
        push_expected(3);
        pulse_start(4'd3);
        wait_done(2000);
        check_eq("resend_bytes", 32'(byte_cnt), 32'(18 + cks_extra()));

        // Oversize request with a second start mid-transfer
        for (int i = 0; i < 64; i++) mem[i] = 16'((i * 16'h0907) ^ 16'h5A3C);
        clear_counts();
        push_expected(8);
        pulse_start(4'd12);
        repeat (100) @(negedge clk);
        pulse_start(4'd3);
        wait_done(6000);
        check_eq("oversize_bytes", 32'(byte_cnt), 32'(128 + cks_extra()));
        check_eq("oversize_reads", 32'(rd_cnt), 64);

`ifdef RESULT_TX_CHECKSUM_EN
        // N=1 checksum: 5A A5 FF
        mem[0] = 16'h5AA5;
        clear_counts();
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hFF);
        pulse_start(4'd1);
        wait_done(1000);
        check_eq("cks_bytes", 32'(byte_cnt), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
